// File: rtl/mult_accum_pkg.sv
// mult_accum_pkg
//   Shared definitions for the product accumulator slice: FSM state type,
//   term-count width helper and the default widths used alongside the
//   2x2 LUT multiplier bench.
//   Optional feature macro: MULT_ACCUM_SAT_EN (see mult_accum.sv).
package mult_accum_pkg;

  localparam int DEF_PROD_W    = 4;
  localparam int DEF_ACC_W     = 8;
  localparam int DEF_NUM_TERMS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  // Width needed to hold a term count in 0..num_terms.
  function automatic int cnt_width(input int num_terms);
    return $clog2(num_terms + 1);
  endfunction

endpackage

// File: rtl/mult_accum_if.sv
// mult_accum_if
//   Input (product) and output (result) valid/ready handshakes of
//   mult_accum.
//   slave  : the accumulator side (consumes prod, produces the result).
//   master : the environment side (supplies prod, consumes the result).
//   Signals: in_valid, in_ready, prod[PROD_W], in_last,
//            out_valid, out_ready, acc_out[ACC_W], term_cnt[CNT_W], overflow.
//   Optional feature macro: MULT_ACCUM_SAT_EN (affects mult_accum only).
interface mult_accum_if import mult_accum_pkg::*; #(
  parameter int PROD_W    = DEF_PROD_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int NUM_TERMS = DEF_NUM_TERMS
) ();

  localparam int CNT_W = cnt_width(NUM_TERMS);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  term_cnt;
  logic              overflow;

  modport master (
    output in_valid, prod, in_last, out_ready,
    input  in_ready, out_valid, acc_out, term_cnt, overflow
  );

  modport slave (
    input  in_valid, prod, in_last, out_ready,
    output in_ready, out_valid, acc_out, term_cnt, overflow
  );

endinterface

// File: rtl/mult_term_counter.sv
// mult_term_counter
//   Counts accepted terms of the current group.
//   Ports: clk, rst (sync, active-high), inc (term accepted), clr (result
//          handshake), cnt (terms so far), last_slot (the next accepted term
//          brings the count to NUM_TERMS).
//   Optional feature macro: MULT_ACCUM_SAT_EN (not used here).
module mult_term_counter #(
  parameter int NUM_TERMS = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last_slot
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Flag derived from the registered count only, so the FSM can use it
  // without a combinational path back through the accept signal.
  assign last_slot = (cnt == CNT_W'(NUM_TERMS - 1));

endmodule

// File: rtl/mult_accum.sv
// mult_accum
//   Sums a group of up to NUM_TERMS unsigned products arriving on a
//   valid/ready handshake and presents sum, term count and a sticky
//   overflow flag on an output valid/ready handshake. One group in flight.
//   Ports: clk, rst (sync, active-high), bus (mult_accum_if.slave).
//   Optional feature macro: MULT_ACCUM_SAT_EN
//     defined   : accumulator saturates to 2^ACC_W-1 on overflow
//     undefined : accumulator wraps modulo 2^ACC_W
module mult_accum import mult_accum_pkg::*; #(
  parameter int PROD_W    = DEF_PROD_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int NUM_TERMS = DEF_NUM_TERMS
) (
  input logic         clk,
  input logic         rst,
  mult_accum_if.slave bus
);

  localparam int CNT_W = cnt_width(NUM_TERMS);

  state_t             state;
  state_t             state_nxt;
  logic               in_ready;
  logic               out_valid;
  logic               accept;
  logic               release_res;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [ACC_W-1:0]   base;
  logic [ACC_W:0]     sum;
  logic [CNT_W-1:0]   cnt;
  logic               last_slot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = (bus.in_last || last_slot) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept      = bus.in_valid && in_ready;
  assign release_res = out_valid && bus.out_ready;

  mult_term_counter #(
    .NUM_TERMS (NUM_TERMS),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (accept),
    .clr       (release_res),
    .cnt       (cnt),
    .last_slot (last_slot)
  );

  // The first term of a group loads rather than adds.
  assign base = (state == IDLE) ? '0 : acc;
  assign sum  = {1'b0, base} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod};

  always_ff @(posedge clk) begin
    if (rst || release_res) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
`ifdef MULT_ACCUM_SAT_EN
      acc <= (sum[ACC_W] || ovf) ? '1 : sum[ACC_W-1:0];
`else
      acc <= sum[ACC_W-1:0];
`endif
      ovf <= ovf | sum[ACC_W];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.acc_out   = acc;
  assign bus.term_cnt  = cnt;
  assign bus.overflow  = ovf;

endmodule

// File: tb/tb_mult_accum.sv
// tb_mult_accum
//   Self-checking bench for mult_accum with PROD_W=4, ACC_W=5, NUM_TERMS=4.
//   Directed group table, multi-cycle corner sequences, then random products
//   from a 2x2 multiply checked against a group-sum reference model.
//   Optional feature macro: MULT_ACCUM_SAT_EN selects saturating expectations.
module tb_mult_accum;

  localparam int PW = 4;
  localparam int AW = 5;
  localparam int NT = 4;
  localparam int MAXV = (1 << AW) - 1;
`ifdef MULT_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mult_accum_if #(.PROD_W(PW), .ACC_W(AW), .NUM_TERMS(NT)) bus ();

  mult_accum #(.PROD_W(PW), .ACC_W(AW), .NUM_TERMS(NT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [15:0] prods;
    bit          last;
    int          exp_acc;
    int          exp_cnt;
    int          exp_ovf;
  } vec_t;

  typedef struct {
    int acc;
    int cnt;
    int ovf;
  } res_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents one term and returns at the negedge after it was accepted.
  task automatic send_term(input logic [PW-1:0] p, input logic l);
    int waitc;
    waitc = 0;
    bus.in_valid = 1'b1;
    bus.prod     = p;
    bus.in_last  = l;
    while (!bus.in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 0, 1);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Reference: result of a whole group from plain arithmetic.
  function automatic res_t group_result(input int terms[$]);
    res_t r;
    int   total;
    total = 0;
    foreach (terms[k]) total += terms[k];
    r.cnt = terms.size();
    r.ovf = (total > MAXV) ? 1 : 0;
    if (SAT) r.acc = (total > MAXV) ? MAXV : total;
    else     r.acc = total % (MAXV + 1);
    return r;
  endfunction

  vec_t vecs[8];

  initial begin
    vecs[0] = '{n:4, prods:16'h4321, last:1'b0, exp_acc:10, exp_cnt:4, exp_ovf:0};
    vecs[1] = '{n:2, prods:16'h0046, last:1'b1, exp_acc:10, exp_cnt:2, exp_ovf:0};
    vecs[2] = '{n:4, prods:16'h9999, last:1'b0, exp_acc:(SAT ? 31 : 4), exp_cnt:4, exp_ovf:1};
    vecs[3] = '{n:1, prods:16'h000F, last:1'b1, exp_acc:15, exp_cnt:1, exp_ovf:0};
    vecs[4] = '{n:4, prods:16'hFFFF, last:1'b1, exp_acc:(SAT ? 31 : 28), exp_cnt:4, exp_ovf:1};
    vecs[5] = '{n:4, prods:16'h0000, last:1'b0, exp_acc:0, exp_cnt:4, exp_ovf:0};
    vecs[6] = '{n:3, prods:16'h02FF, last:1'b1, exp_acc:(SAT ? 31 : 0), exp_cnt:3, exp_ovf:1};
    vecs[7] = '{n:3, prods:16'h01FF, last:1'b1, exp_acc:31, exp_cnt:3, exp_ovf:0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.prod      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_acc_out", int'(bus.acc_out), 0);
    check("reset_term_cnt", int'(bus.term_cnt), 0);
    check("reset_overflow", int'(bus.overflow), 0);

    // Directed groups, back-to-back terms, out_ready held high.
    bus.out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        send_term(vecs[v].prods[4*k +: 4], vecs[v].last && (k == vecs[v].n - 1));
      end
      check($sformatf("vec%0d_out_valid", v), int'(bus.out_valid), 1);
      check($sformatf("vec%0d_acc_out", v), int'(bus.acc_out), vecs[v].exp_acc);
      check($sformatf("vec%0d_term_cnt", v), int'(bus.term_cnt), vecs[v].exp_cnt);
      check($sformatf("vec%0d_overflow", v), int'(bus.overflow), vecs[v].exp_ovf);
      check($sformatf("vec%0d_in_ready_hold", v), int'(bus.in_ready), 0);
      @(negedge clk);
      check($sformatf("vec%0d_out_valid_after", v), int'(bus.out_valid), 0);
      check($sformatf("vec%0d_in_ready_after", v), int'(bus.in_ready), 1);
    end

    // Back-pressure: result held with in_valid asserted for 3 cycles.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_term(4'd1, 1'b0);
    bus.in_valid = 1'b1;
    bus.prod     = 4'd7;
    bus.in_last  = 1'b0;
    for (int r = 0; r < 3; r++) begin
      check("hold_out_valid", int'(bus.out_valid), 1);
      check("hold_acc_out", int'(bus.acc_out), 4);
      check("hold_term_cnt", int'(bus.term_cnt), 4);
      check("hold_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
    end
    check("hold_acc_out_end", int'(bus.acc_out), 4);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_out_valid", int'(bus.out_valid), 0);
    check("release_in_ready", int'(bus.in_ready), 1);
    check("release_acc_out", int'(bus.acc_out), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("post_release_acc", int'(bus.acc_out), 7);
    check("post_release_cnt", int'(bus.term_cnt), 1);
    send_term(4'd1, 1'b1);
    check("post_release_group_acc", int'(bus.acc_out), 8);
    check("post_release_group_cnt", int'(bus.term_cnt), 2);
    check("post_release_group_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Reset in the middle of a group discards it.
    send_term(4'd3, 1'b0);
    send_term(4'd5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_acc_out", int'(bus.acc_out), 0);
    check("midrst_term_cnt", int'(bus.term_cnt), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    check("midrst_no_result", int'(bus.out_valid), 0);
    for (int k = 0; k < 4; k++) send_term(4'd2, 1'b0);
    check("after_rst_acc", int'(bus.acc_out), 8);
    check("after_rst_cnt", int'(bus.term_cnt), 4);
    check("after_rst_ovf", int'(bus.overflow), 0);
    @(negedge clk);
    check("after_rst_release", int'(bus.out_valid), 0);

    // Random products from a 2x2 multiply, random handshakes.
    begin
      int          sent;
      int          cyc;
      int          a;
      int          b;
      bit          pend;
      bit          acc_now;
      logic [PW-1:0] pp;
      logic        pl;
      int          grp[$];
      res_t        res_q[$];
      res_t        r;
      sent = 0;
      cyc  = 0;
      pend = 1'b0;
      pp   = '0;
      pl   = 1'b0;
      while ((sent < 1000 || res_q.size() > 0) && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (!pend && sent < 1000) begin
          a    = int'($urandom_range(0, 3));
          b    = int'($urandom_range(0, 3));
          pp   = PW'(a * b);
          pl   = ($urandom_range(0, 3) == 0) || (sent == 999);
          pend = 1'b1;
        end
        bus.in_valid  = pend && ($urandom_range(0, 3) != 0);
        bus.prod      = pp;
        bus.in_last   = bus.in_valid ? pl : 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        check("rnd_in_ready", int'(bus.in_ready), (res_q.size() == 0) ? 1 : 0);
        check("rnd_out_valid", int'(bus.out_valid), (res_q.size() != 0) ? 1 : 0);
        if (bus.out_valid && bus.out_ready && res_q.size() > 0) begin
          r = res_q.pop_front();
          check("rnd_acc_out", int'(bus.acc_out), r.acc);
          check("rnd_term_cnt", int'(bus.term_cnt), r.cnt);
          check("rnd_overflow", int'(bus.overflow), r.ovf);
        end
        acc_now = bus.in_valid && bus.in_ready;
        if (acc_now) begin
          grp.push_back(int'(pp));
          pend = 1'b0;
          sent++;
          if (pl || grp.size() == NT) begin
            res_q.push_back(group_result(grp));
            grp.delete();
          end
        end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("rnd_terms_sent", sent, 1000);
      check("rnd_results_drained", res_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_accum.md
Name: mult_accum

Overview:
- Sequential consumer sitting directly downstream of the 2x2 LUT multiplier (4-bit product z).
- Accepts one product per cycle over a valid/ready handshake and sums a group of up to NUM_TERMS products.
- Presents the group sum, term count and overflow flag on an output valid/ready handshake.
- Lets post-route benches exercise the multiplier in a clocked, back-pressured context.

Parameters:
- PROD_W, 4, width of the incoming product (matches multiplier z).
- ACC_W, 8, accumulator and result width; must be >= PROD_W.
- NUM_TERMS, 8, maximum products per group; must be >= 1.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  prod is valid this cycle.
- in_ready  output  1  block can accept prod this cycle.
- prod  input  PROD_W  product from the multiplier, unsigned.
- in_last  input  1  qualifies prod as the final term of the group; sampled only on accept.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  group sum.
- term_cnt  output  $clog2(NUM_TERMS+1)  number of terms summed.
- overflow  output  1  sticky within the group; set if the sum exceeded 2^ACC_W-1.

Behaviour:
- Reset: while rst=1 at a rising edge, all registers clear on that edge (synchronous, active-high).
  - After that edge: state=IDLE, accumulator=0, count=0, overflow=0, out_valid=0, in_ready=1, acc_out=0, term_cnt=0.
  - rst takes priority over every handshake. A group that is mid-accumulation or in HOLD is discarded; no result is emitted.
- Accept: a term is accepted when in_valid && in_ready at the rising edge. prod is zero-extended to ACC_W+1 bits and added to the accumulator.
- FSM:
  - IDLE: in_ready=1. An accept loads acc=prod and cnt=1, then goes to ACCUM.
    - If that accept has in_last=1, or NUM_TERMS=1, go to HOLD instead.
  - ACCUM: in_ready=1. Each accept does acc+=prod and cnt+=1.
    - Go to HOLD when the accepted term has in_last=1, or when cnt reaches NUM_TERMS.
  - HOLD: in_ready=0, out_valid=1. acc_out, term_cnt and overflow are stable until out_ready=1.
    - When out_ready=1 at the edge, go to IDLE: acc, cnt and overflow clear, out_valid drops.
- Latency: out_valid rises on the edge after the final term is accepted (1 cycle).
- A new term is accepted no earlier than the cycle after the result handshake. There is no same-cycle bypass, so at most 1 group is ever in flight.
- in_valid with in_ready=0: held upstream (standard valid/ready). The block never drops or duplicates a term.
- out_ready is ignored outside HOLD.
- in_last is ignored when in_valid=0.
- Arithmetic:
  - overflow is set when the (ACC_W+1)-bit sum has its MSB set.
  - The result on overflow is set by the optional feature.
  - overflow stays 1 for the rest of the group.

Optional Feature:
- Macro: MULT_ACCUM_SAT_EN
- Defined: on overflow the accumulator saturates to 2^ACC_W-1 and stays there for further terms.
- Undefined: the accumulator wraps modulo 2^ACC_W.
- overflow is flagged identically in both builds.

Decomposition:
- Package mult_accum_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - a localparam function for the term_cnt width;
  - the default PROD_W, ACC_W and NUM_TERMS constants shared with the multiplier bench.
- One natural sub-module: mult_term_counter.
  - Counts accepts and asserts a terminal flag at NUM_TERMS.
  - Clear on result handshake or rst.
- The FSM and the adder stay in mult_accum.

Test Plan:
- Bench parameters: PROD_W=4, ACC_W=5, NUM_TERMS=4.
- Reset, then accept prods 1, 2, 3, 4 back-to-back with out_ready=1 -> one cycle after the 4th accept: out_valid=1, acc_out=10, term_cnt=4, overflow=0. Then IDLE, in_ready=1.
- Accept 6, then 4 with in_last=1 -> acc_out=10, term_cnt=2; in_ready=0 while out_valid=1.
- Accept 9, 9, 9, 9:
  - with MULT_ACCUM_SAT_EN -> acc_out=31, overflow=1;
  - without it -> acc_out=4, overflow=1.
- Complete a group (1, 1, 1, 1) with out_ready=0 for 3 cycles and in_valid=1 held -> acc_out=4 stable, in_ready=0, no term accepted. out_ready=1 -> handshake, then next term accepted the following cycle.
- Accept 3, 5, then assert rst for 1 cycle -> out_valid=0, acc_out=0, term_cnt=0, no result for the partial group. Then accept 2, 2, 2, 2 -> acc_out=8.
- 1000 random a/b pairs fed through the 2x2 multiplier into mult_accum with random in_valid/out_ready and random in_last -> every acc_out, term_cnt and overflow matches the reference model sum; zero mismatches.
